// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the PS/2 player-input path:
//   - player input-vector bit indices (IN_CENTER .. IN_SHIELD)
//   - PS/2 prefix bytes (E0 extended, F0 break) and every mapped scan code
//   - PS/2 receiver state encoding
//   - map_key(): scan code lookup used by the decoder
// No ports (package).
// -----------------------------------------------------------------------------
package game_pkg;

    // Player input vector layout, 1 = key held.
    localparam int IN_W      = 7;
    localparam int IN_CENTER = 0;
    localparam int IN_LEFT   = 1;
    localparam int IN_RIGHT  = 2;
    localparam int IN_UP     = 3;
    localparam int IN_DOWN   = 4;
    localparam int IN_ATTACK = 5;
    localparam int IN_SHIELD = 6;

    // Prefix bytes.
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Player 1 (all unextended).
    localparam logic [7:0] SC_P1_CENTER = 8'h29;  // space
    localparam logic [7:0] SC_P1_LEFT   = 8'h1C;  // A
    localparam logic [7:0] SC_P1_RIGHT  = 8'h23;  // D
    localparam logic [7:0] SC_P1_UP     = 8'h1D;  // W
    localparam logic [7:0] SC_P1_DOWN   = 8'h1B;  // S
    localparam logic [7:0] SC_P1_ATTACK = 8'h2B;  // F
    localparam logic [7:0] SC_P1_SHIELD = 8'h34;  // G

    // Player 2 (arrows are E0-extended, the rest unextended).
    localparam logic [7:0] SC_P2_CENTER = 8'h5A;  // Enter
    localparam logic [7:0] SC_P2_LEFT   = 8'h6B;  // E0 6B
    localparam logic [7:0] SC_P2_RIGHT  = 8'h74;  // E0 74
    localparam logic [7:0] SC_P2_UP     = 8'h75;  // E0 75
    localparam logic [7:0] SC_P2_DOWN   = 8'h72;  // E0 72
    localparam logic [7:0] SC_P2_ATTACK = 8'h42;  // K
    localparam logic [7:0] SC_P2_SHIELD = 8'h4B;  // L

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef struct packed {
        logic       hit;  // code is mapped for this prefix state
        logic       p2;   // 0 = player 1, 1 = player 2
        logic [2:0] idx;  // bit index in the player vector
    } key_map_t;

    function automatic key_map_t key(input logic p2, input int idx);
        key_map_t k;
        k.hit = 1'b1;
        k.p2  = p2;
        k.idx = 3'(idx);
        return k;
    endfunction

    // Extended and unextended code spaces are disjoint: a base code that is
    // mapped only unextended misses when E0-prefixed, and vice versa.
    function automatic key_map_t map_key(input logic ext, input logic [7:0] code);
        key_map_t k;
        k = '0;
        if (!ext) begin
            case (code)
                SC_P1_CENTER: k = key(1'b0, IN_CENTER);
                SC_P1_LEFT:   k = key(1'b0, IN_LEFT);
                SC_P1_RIGHT:  k = key(1'b0, IN_RIGHT);
                SC_P1_UP:     k = key(1'b0, IN_UP);
                SC_P1_DOWN:   k = key(1'b0, IN_DOWN);
                SC_P1_ATTACK: k = key(1'b0, IN_ATTACK);
                SC_P1_SHIELD: k = key(1'b0, IN_SHIELD);
                SC_P2_CENTER: k = key(1'b1, IN_CENTER);
                SC_P2_ATTACK: k = key(1'b1, IN_ATTACK);
                SC_P2_SHIELD: k = key(1'b1, IN_SHIELD);
                default:      k = '0;
            endcase
        end else begin
            case (code)
                SC_P2_LEFT:   k = key(1'b1, IN_LEFT);
                SC_P2_RIGHT:  k = key(1'b1, IN_RIGHT);
                SC_P2_UP:     k = key(1'b1, IN_UP);
                SC_P2_DOWN:   k = key(1'b1, IN_DOWN);
                default:      k = '0;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// -----------------------------------------------------------------------------
// ps2_rx
// PS/2 device-to-host frame receiver: synchronizes ps2_clk/ps2_data, detects
// ps2_clk falling edges, shifts in start/8 data (LSB first)/parity/stop, and
// aborts a frame whose clock stalls for TIMEOUT_CYCLES.
// Optional build macro: PS2_PARITY_CHECK_EN -- when defined, frames with even
// parity over data+parity are discarded; otherwise the parity bit is ignored.
// Parameters:
//   SYNC_STAGES    synchronizer depth on ps2_clk/ps2_data (min 2)
//   TIMEOUT_CYCLES clk cycles without a falling edge before aborting a frame
// Ports:
//   clk, reset     system clock, synchronous active-low reset
//   ps2_clk        asynchronous PS/2 clock
//   ps2_data       asynchronous PS/2 data
//   rx_byte        last accepted byte (valid with byte_valid)
//   byte_valid     one-cycle pulse, the cycle after the stop edge is detected
//   frame_err      one-cycle pulse per discarded or timed-out frame
// -----------------------------------------------------------------------------
module ps2_rx
    import game_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;

    // NOTE: synchronizer flops carry no reset; they settle from the idle-high
    // bus within SYNC_STAGES cycles and resetting them gains nothing.
    always_ff @(posedge clk) begin
        clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
        data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end

    // Falling edge between the last two clock stages. Data is taken from the
    // last data stage: PS/2 holds data stable for the whole low phase, so the
    // extra stage of lag is harmless.
    logic fall;
    logic bit_in;
    assign fall   = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
    assign bit_in = data_sync[SYNC_STAGES-1];

    rx_state_e    state_q, state_d;
    logic [2:0]   bit_cnt;
    logic [7:0]   shift_q;
    logic [TW-1:0] idle_cnt;
    logic         parity_ok;
    logic         timeout;
    logic         shift_en;
    logic         done_ok;
    logic         done_bad;

`ifdef PS2_PARITY_CHECK_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (!reset)
            par_q <= 1'b0;
        else if (fall && state_q == RX_PARITY)
            par_q <= bit_in;
    end

    // Odd parity over data + parity bit.
    assign parity_ok = ^{shift_q, par_q};
`else
    assign parity_ok = 1'b1;
`endif

    // Counter holds the cycles elapsed since the last falling edge; the abort
    // fires on the cycle the count would reach TIMEOUT_CYCLES.
    assign timeout = (state_q != RX_IDLE) && !fall &&
                     (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        done_ok  = 1'b0;
        done_bad = 1'b0;
        if (timeout) begin
            state_d  = RX_IDLE;
            done_bad = 1'b1;
        end else if (fall) begin
            case (state_q)
                RX_IDLE: begin
                    if (!bit_in)
                        state_d = RX_DATA;
                end
                RX_DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7)
                        state_d = RX_PARITY;
                end
                RX_PARITY: begin
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    state_d = RX_IDLE;
                    if (bit_in && parity_ok)
                        done_ok = 1'b1;
                    else
                        done_bad = 1'b1;
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= RX_IDLE;
            bit_cnt    <= '0;
            shift_q    <= '0;
            idle_cnt   <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_valid <= done_ok;
            frame_err  <= done_bad;
            if (done_ok)
                rx_byte <= shift_q;
            if (state_q == RX_IDLE)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + 3'd1;
            if (shift_en)
                shift_q <= {bit_in, shift_q[7:1]};  // LSB arrives first
            if (fall || state_q == RX_IDLE)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_player_inputs.sv
// -----------------------------------------------------------------------------
// ps2_player_inputs
// Turns a PS/2 keyboard byte stream into two held-key vectors for the game
// core. E0 marks the next code as extended, F0 marks it as a release; both
// flags persist until the next non-prefix byte, which consumes them.
// Optional build macro: PS2_PARITY_CHECK_EN (enables parity check in ps2_rx).
// Parameters: SYNC_STAGES, TIMEOUT_CYCLES (passed to ps2_rx).
// Ports:
//   clk, reset     system clock, synchronous active-low reset
//   ps2_clk        asynchronous PS/2 clock
//   ps2_data       asynchronous PS/2 data
//   p1_inputs      player-1 held keys [center,left,right,up,down,attack,shield]
//   p2_inputs      player-2 held keys, same layout
//   frame_err      one-cycle pulse per discarded frame
// -----------------------------------------------------------------------------
module ps2_player_inputs
    import game_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    output logic [IN_W-1:0] p1_inputs,
    output logic [IN_W-1:0] p2_inputs,
    output logic            frame_err
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       ext_pending;
    logic       break_pending;
    key_map_t   hit;

    ps2_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign hit = map_key(ext_pending, rx_byte);

    // Make/break simply set/clear the bit, so typematic repeats and releases
    // of unheld keys are naturally idempotent; opposing keys are not arbitrated.
    always_ff @(posedge clk) begin
        if (!reset) begin
            p1_inputs     <= '0;
            p2_inputs     <= '0;
            ext_pending   <= 1'b0;
            break_pending <= 1'b0;
        end else if (byte_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_pending <= 1'b1;
            end else if (rx_byte == SC_BRK) begin
                break_pending <= 1'b1;
            end else begin
                ext_pending   <= 1'b0;
                break_pending <= 1'b0;
                if (hit.hit) begin
                    if (hit.p2)
                        p2_inputs[hit.idx] <= ~break_pending;
                    else
                        p1_inputs[hit.idx] <= ~break_pending;
                end
            end
        end
    end

endmodule

// File: doc/ps2_player_inputs.md
PS2_PLAYER_INPUTS -- requirements
Module: ps2_player_inputs

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops on ps2_clk/ps2_data (min 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning clk cycles without a ps2_clk falling edge before an in-progress frame is aborted.
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-005 SHALL have port ps2_clk, input, 1, asynchronous PS/2 keyboard clock.
REQ-006 SHALL have port ps2_data, input, 1, asynchronous PS/2 keyboard data.
REQ-007 SHALL have port p1_inputs, output, 7, player-1 held-key vector for the game core.
REQ-008 SHALL have port p2_inputs, output, 7, player-2 held-key vector for the game core.
REQ-009 SHALL have port frame_err, output, 1, one-cycle pulse per discarded frame.

Function
REQ-010 SHALL use input-vector bit order [0] center, [1] left, [2] right, [3] up, [4] down, [5] attack, [6] shield; 1 = key held.
REQ-011 SHALL map P1: 29 space=center, 1C A=left, 23 D=right, 1D W=up, 1B S=down, 2B F=attack, 34 G=shield.
REQ-012 SHALL map P2: 5A Enter=center, E0 6B=left, E0 74=right, E0 75=up, E0 72=down, 42 K=attack, 4B L=shield.
REQ-013 SHALL sample ps2_data on each synchronized ps2_clk falling edge (1->0 between last two sync stages).
REQ-014 SHALL run receiver FSM IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE; IDLE leaves only on a falling edge with data=0 (start bit).
REQ-015 SHALL accept a frame only if stop bit=1 and parity is odd over data+parity; otherwise discard, return to IDLE, pulse frame_err.
REQ-016 SHALL, while not IDLE, count clk cycles since the last falling edge and on reaching TIMEOUT_CYCLES abort to IDLE, pulse frame_err, leave decoder flags unchanged.
REQ-017 SHALL present accepted byte as a one-cycle byte_valid the cycle after the stop-bit edge is detected; outputs update on the next cycle (2-cycle latency from detected stop edge).
REQ-018 SHALL set ext_pending on byte E0 and break_pending on byte F0; both persist until the next non-prefix byte.
REQ-019 SHALL, on a non-prefix byte, look up (ext_pending, code): match -> set bit if break_pending=0, clear if 1; then clear both flags.
REQ-020 SHALL clear both flags and leave outputs unchanged on unmapped codes, including E0-prefixed codes whose base code is mapped only unextended (and vice versa).
REQ-021 SHALL treat repeated make codes (typematic) as idempotent sets; break of an unheld key is an idempotent clear.
REQ-022 SHALL allow opposing bits (left+right) simultaneously; arbitration belongs to the game core.
REQ-023 SHALL hold at most one frame in flight; no buffering or backpressure.

Reset
REQ-024 SHALL on reset=0 at a clk edge: p1_inputs=0, p2_inputs=0, frame_err=0, FSM=IDLE, bit/timeout counters=0, flags=0, byte_valid=0.
REQ-025 SHALL drop a frame in progress at reset without pulsing frame_err; synchronizer flops need not reset.

Configuration
REQ-026 SHALL, with PS2_PARITY_CHECK_EN defined, apply the parity check of REQ-015.
REQ-027 SHALL, without PS2_PARITY_CHECK_EN, ignore the parity bit; stop-bit and timeout checks remain.

Structure
REQ-028 SHALL place input bit indices (IN_CENTER..IN_SHIELD), prefix codes E0/F0 and all mapped scan codes in shared package game_pkg.
REQ-029 SHALL isolate sync, edge detect, frame FSM, timeout and parity in sub-module ps2_rx (outputs byte, byte_valid, frame_err); decode/map logic stays in ps2_player_inputs.

Verification
REQ-030 SHALL: frame 1C (parity 0, stop 1) -> p1_inputs=0000010 two cycles after stop edge; then F0,1C -> p1_inputs=0000000.
REQ-031 SHALL: E0,75 -> p2_inputs=0001000; E0,F0,75 -> 0000000; bare 75 -> no change, flags cleared.
REQ-032 SHALL: 1C with parity bit flipped -> frame_err one-cycle pulse, p1_inputs unchanged; without PS2_PARITY_CHECK_EN -> p1_inputs=0000010.
REQ-033 SHALL: stop ps2_clk after 4 data bits for TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; next valid 2B -> p1_inputs[5]=1.
REQ-034 SHALL: 1C,23,42,4B held, then reset=0 one cycle -> all outputs 0; mid-frame reset -> no frame_err, next frame decoded correctly.
REQ-035 SHALL: 1C sent 5 times (typematic), one F0,1C -> p1_inputs[1]=0; unmapped 15 -> no change, no frame_err.
